// File: rtl/md_ctl_pkg.sv
// rtl/md_ctl_pkg.sv - shared types and constants for the MD timestep sequencer
// State encoding, default widths and the watchdog timeout helper.
package md_ctl_pkg;

  localparam int STEP_W_DEF = 32;
  localparam int WDOG_W_DEF = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1_ARM,
    S_P1_RUN,
    S_P1_DRAIN,
    S_P2_RUN,
    S_SWAP,
    S_ERROR
  } seq_state_t;

  // Watchdog timeout in cycles for a counter of width w (all-ones value).
  function automatic logic [63:0] wdog_timeout(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/md_timestep_sequencer_if.sv
// rtl/md_timestep_sequencer_if.sv - host/phase handshake bundle for the sequencer
// MD_SEQ_PERF_EN adds the p1_cycles/p2_cycles performance outputs.
interface md_timestep_sequencer_if
  import md_ctl_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEF
);
  logic              start;
  logic [STEP_W-1:0] n_steps;
  logic              abort;
  logic              p1_ready;
  logic              p1_done;
  logic              double_buffer;
  logic              p2_start;
  logic              p2_done;
  logic              busy;
  logic [STEP_W-1:0] step_count;
  logic              run_done;
  logic              error;
`ifdef MD_SEQ_PERF_EN
  logic [31:0]       p1_cycles;
  logic [31:0]       p2_cycles;
`endif

  modport slave (
    input  start, n_steps, abort, p1_done, p2_done,
`ifdef MD_SEQ_PERF_EN
    output p1_cycles, p2_cycles,
`endif
    output p1_ready, double_buffer, p2_start, busy, step_count, run_done, error
  );

  modport master (
    output start, n_steps, abort, p1_done, p2_done,
`ifdef MD_SEQ_PERF_EN
    input  p1_cycles, p2_cycles,
`endif
    input  p1_ready, double_buffer, p2_start, busy, step_count, run_done, error
  );

endinterface

// File: rtl/md_seq_watchdog.sv
// rtl/md_seq_watchdog.sv - loadable up/down counter with terminal-count flag
// Used both as the phase watchdog and as the post-phase-1 drain counter.
module md_seq_watchdog #(
  parameter int           W    = 24,
  parameter bit           DOWN = 1'b0,
  parameter logic [W-1:0] TC   = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic [W-1:0] i_load,
  input  logic         i_en,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= i_load;
    end else if (i_en) begin
      r_cnt <= DOWN ? (r_cnt - W'(1)) : (r_cnt + W'(1));
    end
  end

  assign o_tc = (r_cnt == TC);

endmodule

// File: rtl/md_timestep_sequencer.sv
// rtl/md_timestep_sequencer.sv - runs N MD timesteps through phase 1 and phase 2
// Optional MD_SEQ_PERF_EN: per-step P1_RUN / P2_RUN cycle counters.
module md_timestep_sequencer
  import md_ctl_pkg::*;
#(
  parameter int STEP_W       = STEP_W_DEF,
  parameter int DRAIN_CYCLES = 4,
  parameter int WDOG_W       = WDOG_W_DEF
) (
  input logic                    clk,
  input logic                    reset,
  md_timestep_sequencer_if.slave bus
);

  localparam logic [WDOG_W-1:0] WDOG_TC = WDOG_W'(wdog_timeout(WDOG_W));

  seq_state_t        r_state, w_next;
  logic [STEP_W-1:0] r_n_steps, r_step_count;
  logic              r_db, r_error, r_zero_done;
  logic              r_p1_q, r_p1_flag;
  logic              w_wdog_tc, w_drain_tc, w_wdog_clr, w_drain_clr;
  logic              w_start_ok, w_last;
  logic              w_p1_ready, w_p2_start, w_busy, w_run_done;

  assign w_start_ok = bus.start && (r_state == S_IDLE || r_state == S_ERROR);
  assign w_last     = ((r_step_count + STEP_W'(1)) == r_n_steps);

  // Watchdog starts at 1 so the all-ones value is hit after exactly 2^W-1 cycles in a phase.
  assign w_wdog_clr  = (r_state == S_P1_ARM) || (r_state == S_P1_DRAIN && w_next == S_P2_RUN);
  assign w_drain_clr = (r_state == S_P1_RUN) && (w_next == S_P1_DRAIN);

  md_seq_watchdog #(.W(WDOG_W), .DOWN(1'b0), .TC(WDOG_TC)) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_wdog_clr),
    .i_load (WDOG_W'(1)),
    .i_en   (r_state == S_P1_RUN || r_state == S_P2_RUN),
    .o_tc   (w_wdog_tc)
  );

  md_seq_watchdog #(.W(8), .DOWN(1'b1), .TC(8'd1)) u_drain (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_drain_clr),
    .i_load (8'(DRAIN_CYCLES)),
    .i_en   (r_state == S_P1_DRAIN),
    .o_tc   (w_drain_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_ERROR: if (bus.start) w_next = (bus.n_steps == '0) ? S_IDLE : S_P1_ARM;
        S_P1_ARM:        w_next = S_P1_RUN;
        S_P1_RUN:        if (w_wdog_tc) w_next = S_ERROR;
                         else if (r_p1_flag) w_next = S_P1_DRAIN;
        S_P1_DRAIN:      if (w_drain_tc) w_next = S_P2_RUN;
        S_P2_RUN:        if (w_wdog_tc) w_next = S_ERROR;
                         else if (bus.p2_done) w_next = S_SWAP;
        S_SWAP:          w_next = w_last ? S_IDLE : S_P1_ARM;
        default:         w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_p1_ready = (r_state == S_P1_ARM);
    w_p2_start = (r_state == S_P1_DRAIN) && w_drain_tc && !bus.abort;
    w_busy     = (r_state != S_IDLE) && (r_state != S_ERROR);
    w_run_done = r_zero_done || ((r_state == S_SWAP) && w_last && !bus.abort);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_n_steps    <= '0;
      r_step_count <= '0;
      r_db         <= 1'b0;
      r_error      <= 1'b0;
      r_zero_done  <= 1'b0;
      r_p1_q       <= 1'b0;
      r_p1_flag    <= 1'b0;
    end else begin
      r_p1_q      <= bus.p1_done;
      r_zero_done <= 1'b0;
      // Stale done levels are ignored: only a rise after arming counts.
      if (r_state == S_P1_ARM)              r_p1_flag <= 1'b0;
      else if (bus.p1_done && !r_p1_q)      r_p1_flag <= 1'b1;
      if (w_start_ok && !bus.abort) begin
        r_n_steps    <= bus.n_steps;
        r_step_count <= '0;
        r_error      <= 1'b0;
        r_zero_done  <= (bus.n_steps == '0);
      end
      if (r_state == S_SWAP && !bus.abort) begin
        r_db         <= ~r_db;
        r_step_count <= r_step_count + STEP_W'(1);
      end
      if (w_next == S_ERROR) r_error <= 1'b1;
    end
  end

  assign bus.p1_ready      = w_p1_ready;
  assign bus.p2_start      = w_p2_start;
  assign bus.busy          = w_busy;
  assign bus.run_done      = w_run_done;
  assign bus.double_buffer = r_db;
  assign bus.step_count    = r_step_count;
  assign bus.error         = r_error;

`ifdef MD_SEQ_PERF_EN
  logic [31:0] r_p1_cnt, r_p2_cnt, r_p1_cycles, r_p2_cycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p1_cnt    <= '0;
      r_p2_cnt    <= '0;
      r_p1_cycles <= '0;
      r_p2_cycles <= '0;
    end else begin
      if (r_state == S_P1_ARM) begin
        r_p1_cnt <= '0;
        r_p2_cnt <= '0;
      end else begin
        if (r_state == S_P1_RUN && r_p1_cnt != '1) r_p1_cnt <= r_p1_cnt + 32'd1;
        if (r_state == S_P2_RUN && r_p2_cnt != '1) r_p2_cnt <= r_p2_cnt + 32'd1;
      end
      if (r_state == S_SWAP && !bus.abort) begin
        r_p1_cycles <= r_p1_cnt;
        r_p2_cycles <= r_p2_cnt;
      end
    end
  end

  assign bus.p1_cycles = r_p1_cycles;
  assign bus.p2_cycles = r_p2_cycles;
`endif

endmodule
